// File: rtl/audio_dac_i2s_out_if.sv
// Sample push handshake between the DRAM playback mover (master) and the
// I2S output stage (slave). audio_out carries left in [32:17], right in [16:1].
interface audio_dac_i2s_out_if;
  logic [32:1] audio_out;
  logic        write_audio_out;
  logic        audio_out_allowed;

  modport master (
    output audio_out,
    output write_audio_out,
    input  audio_out_allowed
  );

  modport slave (
    input  audio_out,
    input  write_audio_out,
    output audio_out_allowed
  );
endinterface

// File: rtl/audio_dac_i2s_out.sv
// I2S playback stage: 8-deep sample FIFO, BCLK/LRCK generation from CLOCK_50, MSB-first
// serialiser. Define AUDIO_DAC_MONO_DUP_EN to play audio_out[16:1] on both channels.
module audio_dac_i2s_out #(
  parameter int ADDR_W    = 3,
  parameter int BCLK_HALF = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  audio_dac_i2s_out_if.slave aud,
  input  logic               clear_underrun,
  output logic               underrun,
  output logic [ADDR_W:0]    fifo_level,
  output logic               AUD_BCLK,
  output logic               AUD_DACLRCK,
  output logic               AUD_DACDAT
);
  localparam int                DEPTH      = 1 << ADDR_W;
  localparam int                DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [DIV_W-1:0]  divcnt_q, divcnt_d;
  logic              bclk_q, bclk_d;
  logic [5:0]        bitcnt_q, bitcnt_d;
  logic              lrck_q, lrck_d;
  logic              dat_q, dat_d;
  logic [32:1]       hold_q, hold_d;
  logic              underrun_q, underrun_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [32:1]       mem_q [DEPTH];

  logic        div_wrap, fall, frame_load, not_full, push, pop;
  logic [32:1] head_word;

  assign div_wrap   = (divcnt_q == DIV_LAST);
  assign fall       = div_wrap & bclk_q;
  assign frame_load = fall & (bitcnt_q == 6'd63);
  assign not_full   = (level_q != LEVEL_FULL);
  assign push       = aud.write_audio_out & not_full;
  assign pop        = frame_load & (level_q != '0);

`ifdef AUDIO_DAC_MONO_DUP_EN
  logic [32:17] unused_left;
  assign unused_left = mem_q[rd_ptr_q][32:17];
  assign head_word   = {mem_q[rd_ptr_q][16:1], mem_q[rd_ptr_q][16:1]};
`else
  assign head_word   = mem_q[rd_ptr_q];
`endif

  // FIFO bookkeeping; a full FIFO never accepts, so a pop at the wrap cannot race a push.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  logic [4:0]  slot_pos;
  logic [4:0]  bit_idx;
  logic [15:0] chan;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    divcnt_d   = div_wrap ? '0 : divcnt_q + DIV_ONE;
    bclk_d     = bclk_q ^ div_wrap;
    bitcnt_d   = bitcnt_q;
    lrck_d     = lrck_q;
    dat_d      = dat_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    slot_pos   = '0;
    bit_idx    = '0;
    chan       = '0;

    if (clear_underrun) underrun_d = 1'b0;

    if (frame_load) begin
      if (level_q != '0) begin
        hold_d = head_word;
      end else begin
        hold_d     = '0;
        underrun_d = 1'b1;
      end
    end

    // Slot bit p=1..16 carries channel bit 16-p; p=0 and p=17..31 are padding zeros.
    if (fall) begin
      bitcnt_d = bitcnt_q + 6'd1;
      lrck_d   = bitcnt_d[5];
      slot_pos = bitcnt_d[4:0];
      chan     = bitcnt_d[5] ? hold_d[16:1] : hold_d[32:17];
      bit_idx  = 5'd16 - slot_pos;
      dat_d    = (slot_pos >= 5'd1 && slot_pos <= 5'd16) ? chan[bit_idx[3:0]] : 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      divcnt_q   <= '0;
      bclk_q     <= 1'b0;
      bitcnt_q   <= '0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      divcnt_q   <= divcnt_d;
      bclk_q     <= bclk_d;
      bitcnt_q   <= bitcnt_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // NOTE: the sample store is deliberately not reset; clearing the pointers and
  // level is enough to discard its contents, and it stays a plain RAM.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= aud.audio_out;
  end

  assign aud.audio_out_allowed = not_full;
  assign fifo_level            = level_q;
  assign underrun              = underrun_q;
  assign AUD_BCLK              = bclk_q;
  assign AUD_DACLRCK           = lrck_q;
  assign AUD_DACDAT            = dat_q;
endmodule

// File: tb/tb_audio_dac_i2s_out.sv
// Self-checking bench for audio_dac_i2s_out: a timeline model (edges since reset release,
// frame queue) predicts every output each cycle; literal checks pin the key scenarios.
module tb_audio_dac_i2s_out;
  localparam int H     = 8;
  localparam int DEPTH = 8;
  localparam int FRAME = 2 * H * 64;

  logic clk;
  logic rst_n;
  logic clr;
  logic underrun;
  logic [3:0] fifo_level;
  logic dac_bclk, dac_lrck, dac_dat;

  audio_dac_i2s_out_if bus ();

  audio_dac_i2s_out #(.ADDR_W(3), .BCLK_HALF(H)) dut (
    .CLOCK_50       (clk),
    .reset          (rst_n),
    .aud            (bus),
    .clear_underrun (clr),
    .underrun       (underrun),
    .fifo_level     (fifo_level),
    .AUD_BCLK       (dac_bclk),
    .AUD_DACLRCK    (dac_lrck),
    .AUD_DACDAT     (dac_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, pending samples, sample now playing.
  int          m_t;
  logic [31:0] m_q [$];
  logic [31:0] m_cur;
  logic        m_und;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  // Outputs implied by the I2S timeline: edge t -> fall count -> bit slot.
  function automatic logic [2:0] expect_out(input int t, input logic [31:0] cur);
    int n, bc, p;
    logic [15:0] ch;
    logic b, l, d;
    n  = t / (2 * H);
    bc = n % 64;
    p  = bc % 32;
    b  = ((t / H) % 2) == 1;
    l  = (bc >= 32);
    ch = l ? cur[15:0] : cur[31:16];
    d  = (p >= 1 && p <= 16) ? ch[16 - p] : 1'b0;
    return {b, l, d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nt, sz;
    logic acc, wrap;
    logic [31:0] hd;
    if (!rst_n) begin
      m_t   <= 0;
      m_cur <= '0;
      m_und <= 1'b0;
      m_q.delete();
    end else begin
      nt   = m_t + 1;
      sz   = m_q.size();
      acc  = bus.write_audio_out && (sz < DEPTH);
      wrap = (nt % FRAME) == 0;
      m_t <= nt;
      if (clr) m_und <= 1'b0;
      if (wrap) begin
        if (sz > 0) begin
          hd = m_q.pop_front();
          m_cur <= hd;
        end else begin
          m_cur <= '0;
          m_und <= 1'b1;
        end
      end
      if (acc) begin
`ifdef AUDIO_DAC_MONO_DUP_EN
        m_q.push_back({bus.audio_out[16:1], bus.audio_out[16:1]});
`else
        m_q.push_back(bus.audio_out);
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    e = expect_out(m_t, m_cur);
    check("bclk",     dac_bclk, e[2]);
    check("lrck",     dac_lrck, e[1]);
    check("dat",      dac_dat,  e[0]);
    check("underrun", underrun, m_und);
    check("level",    fifo_level, m_q.size());
    check("allowed",  bus.audio_out_allowed, m_q.size() != DEPTH);
  end

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while (m_t < target && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    if (m_t < target) check("wait_t_timeout", m_t, target);
  endtask

  task automatic capture(input int base, input int first_n, output logic [15:0] v);
    for (int p = 0; p < 16; p++) begin
      wait_t(base + 2 * H * (first_n + p));
      v[15 - p] = dac_dat;
    end
  endtask

  task automatic push_one(input logic [31:0] d);
    bus.write_audio_out = 1'b1;
    bus.audio_out       = d;
    @(negedge clk);
    bus.write_audio_out = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [31:0] sample;
    logic [15:0] exp_l, exp_r;
`ifdef AUDIO_DAC_MONO_DUP_EN
    sample = 32'h1234_BEEF;
    exp_l  = 16'hBEEF;
    exp_r  = 16'hBEEF;
`else
    sample = 32'hA5A5_0F0F;
    exp_l  = 16'hA5A5;
    exp_r  = 16'h0F0F;
`endif
    rst_n = 1'b0;
    clr = 1'b0;
    bus.write_audio_out = 1'b0;
    bus.audio_out = '0;
    repeat (3) @(negedge clk);
    check("rst_level", fifo_level, 0);
    check("rst_allowed", bus.audio_out_allowed, 1);
    check("rst_bclk", dac_bclk, 0);
    rst_n = 1'b1;

    wait_t(H);      check("first_rise", dac_bclk, 1);
    wait_t(2 * H);  check("first_fall", dac_bclk, 0);
    wait_t(100);
    push_one(sample);
    wait_t(512);    check("lrck_right_half", dac_lrck, 1);
    wait_t(1023);
    check("pre_wrap_level", fifo_level, 1);
    check("pre_wrap_underrun", underrun, 0);
    capture(FRAME, 1, cap);  check("left_slot", cap, exp_l);
    check("popped_level", fifo_level, 0);
    capture(FRAME, 33, cap); check("right_slot", cap, exp_r);

    // Nine back-to-back pushes inside one frame: the ninth must bounce.
    wait_t(1800);
    for (int i = 0; i < 9; i++) begin
      bus.write_audio_out = 1'b1;
      bus.audio_out = $urandom;
      @(negedge clk);
      if (i == 7) begin
        check("full_level", fifo_level, 8);
        check("full_allowed", bus.audio_out_allowed, 0);
      end
    end
    bus.write_audio_out = 1'b0;
    check("ninth_ignored", fifo_level, 8);

    // Push held across the wrap: rejected at the pop edge, accepted one cycle later.
    wait_t(2 * FRAME - 1);
    bus.write_audio_out = 1'b1;
    bus.audio_out = 32'hDEAD_0001;
    @(negedge clk);
    check("wrap_pop_level", fifo_level, 7);
    check("wrap_allowed", bus.audio_out_allowed, 1);
    bus.audio_out = 32'hC0DE_0002;
    @(negedge clk);
    bus.write_audio_out = 1'b0;
    check("refill_level", fifo_level, 8);

    // Eight more frames drain the FIFO, then one boundary passes empty.
    wait_t(11 * FRAME - 1); check("no_underrun_yet", underrun, 0);
    wait_t(11 * FRAME);     check("underrun_set", underrun, 1);
    wait_t(11 * FRAME + 36);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("underrun_cleared", underrun, 0);

    // Reset mid right slot with five samples queued.
    wait_t(12 * FRAME + 12);
    for (int i = 0; i < 5; i++) begin
      bus.write_audio_out = 1'b1;
      bus.audio_out = $urandom;
      @(negedge clk);
    end
    bus.write_audio_out = 1'b0;
    wait_t(12 * FRAME + 2 * H * 40 + 4);
    check("pre_rst_lrck", dac_lrck, 1);
    check("pre_rst_level", fifo_level, 5);
    check("pre_rst_underrun", underrun, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_lrck", dac_lrck, 0);
    check("async_level", fifo_level, 0);
    check("async_allowed", bus.audio_out_allowed, 1);
    check("async_underrun", underrun, 0);
    check("async_bclk", dac_bclk, 0);
    check("async_dat", dac_dat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 7000; c++) begin
      bus.write_audio_out = ($urandom_range(0, 699) == 0);
      bus.audio_out = $urandom;
      clr = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    bus.write_audio_out = 1'b0;
    clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
